// File: rtl/rsa_decrypt_ctrl.sv
// RSA decryption sequencer: loads a p/q/e + ciphertext burst, finds d = e^-1 mod phi,
// runs each ciphertext through an external modexp engine, then replays the plaintexts.
module rsa_decrypt_ctrl #(
    parameter int NWORDS = 8,
    parameter int DW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [3:0]    in_p,
    input  logic [3:0]    in_q,
    input  logic [DW-1:0] in_e,
    input  logic [DW-1:0] in_c,
    output logic          exp_req,
    output logic [DW-1:0] exp_base,
    output logic [DW-1:0] exp_exp,
    output logic [DW-1:0] exp_mod,
    input  logic          exp_ack,
    input  logic [DW-1:0] exp_res,
    output logic          out_valid,
    output logic [DW-1:0] out_m
);

    localparam int KW = $clog2(NWORDS + 1);
    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT_KEY, S_ISSUE, S_HOLD, S_OUT
    } state_t;

    typedef enum logic [1:0] {
        KS_IDLE, KS_MOD, KS_SEARCH, KS_DONE
    } ks_t;

    state_t        state_q;
    ks_t           ks_q;
    logic [KW-1:0] k_q;
    logic [DW-1:0] buf_q [NWORDS];

    logic [DW-1:0] n_q, phi_q, er_q, acc_q, cand_q, d_q;

    logic          exp_req_q;
    logic [DW-1:0] exp_base_q, exp_exp_q, exp_mod_q;
    logic          out_valid_q;
    logic [DW-1:0] out_m_q;

    logic          ks_start;
    logic [DW-1:0] n_d, phi_d, acc_d;
    logic [DW:0]   acc_sum_d;

    assign ks_start  = (state_q == S_IDLE) && in_valid;
    assign n_d       = DW'(in_p) * DW'(in_q);
    assign phi_d     = DW'(in_p - 4'd1) * DW'(in_q - 4'd1);
    assign acc_sum_d = {1'b0, acc_q} + {1'b0, er_q};
    assign acc_d     = (acc_sum_d >= {1'b0, phi_q}) ? DW'(acc_sum_d - {1'b0, phi_q})
                                                    : acc_sum_d[DW-1:0];

    // Key search: acc tracks cand*e mod phi; the first cand giving 1 is d.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ks_q   <= KS_IDLE;
            n_q    <= '0;
            phi_q  <= '0;
            er_q   <= '0;
            acc_q  <= '0;
            cand_q <= '0;
            d_q    <= '0;
        end else if (ks_start) begin
            ks_q   <= KS_MOD;
            n_q    <= n_d;
            phi_q  <= phi_d;
            er_q   <= in_e;
            acc_q  <= '0;
            cand_q <= DW'(1);
            d_q    <= '0;
        end else begin
            case (ks_q)
                KS_MOD: begin
                    if (phi_q <= DW'(2)) begin
                        d_q  <= DW'(1);
                        ks_q <= KS_DONE;
                    end else if (er_q >= phi_q) begin
                        er_q <= er_q - phi_q;
                    end else begin
                        acc_q  <= er_q;
                        cand_q <= DW'(1);
                        ks_q   <= KS_SEARCH;
                    end
                end
                KS_SEARCH: begin
                    if (acc_q == DW'(1)) begin
                        d_q  <= cand_q;
                        ks_q <= KS_DONE;
                    end else if (cand_q >= phi_q - DW'(1)) begin
                        // no inverse exists: fall back to d=1 rather than spin
                        d_q  <= DW'(1);
                        ks_q <= KS_DONE;
                    end else begin
                        acc_q  <= acc_d;
                        cand_q <= cand_q + DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            for (int i = 0; i < NWORDS; i++) buf_q[i] <= '0;
            exp_req_q   <= 1'b0;
            exp_base_q  <= '0;
            exp_exp_q   <= '0;
            exp_mod_q   <= '0;
            out_valid_q <= 1'b0;
            out_m_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        buf_q[0] <= in_c;
                        k_q      <= KW'(1);
                        state_q  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        buf_q[k_q[IW-1:0]] <= in_c;
                        k_q                <= k_q + KW'(1);
                        if (k_q == KW'(NWORDS - 1)) state_q <= S_WAIT_KEY;
                    end
                end
                S_WAIT_KEY: begin
                    if (ks_q == KS_DONE) begin
                        k_q     <= '0;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    exp_req_q  <= 1'b1;
                    exp_base_q <= buf_q[k_q[IW-1:0]];
                    exp_exp_q  <= d_q;
                    exp_mod_q  <= n_q;
                    state_q    <= S_HOLD;
                end
                S_HOLD: begin
                    // results overwrite their ciphertext slot in place
                    if (exp_ack) begin
                        buf_q[k_q[IW-1:0]] <= exp_res;
                        exp_req_q          <= 1'b0;
                        if (k_q == KW'(NWORDS - 1)) begin
                            out_valid_q <= 1'b1;
                            out_m_q     <= buf_q[0];
                            k_q         <= KW'(1);
                            state_q     <= S_OUT;
                        end else begin
                            k_q     <= k_q + KW'(1);
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_OUT: begin
                    if (k_q == KW'(NWORDS)) begin
                        out_valid_q <= 1'b0;
                        out_m_q     <= '0;
                        k_q         <= '0;
                        state_q     <= S_IDLE;
                    end else begin
                        out_m_q <= buf_q[k_q[IW-1:0]];
                        k_q     <= k_q + KW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign exp_req   = exp_req_q;
    assign exp_base  = exp_base_q;
    assign exp_exp   = exp_exp_q;
    assign exp_mod   = exp_mod_q;
    assign out_valid = out_valid_q;
    assign out_m     = out_m_q;

endmodule

// File: tb/tb_rsa_decrypt_ctrl.sv
// Directed bench for rsa_decrypt_ctrl with a behavioural modexp engine.
module tb_rsa_decrypt_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_p, in_q;
    logic [7:0] in_e, in_c;
    logic       exp_req;
    logic [7:0] exp_base, exp_exp, exp_mod;
    logic       exp_ack;
    logic [7:0] exp_res;
    logic       out_valid;
    logic [7:0] out_m;

    rsa_decrypt_ctrl #(.NWORDS(8), .DW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_p(in_p), .in_q(in_q),
        .in_e(in_e), .in_c(in_c), .exp_req(exp_req), .exp_base(exp_base),
        .exp_exp(exp_exp), .exp_mod(exp_mod), .exp_ack(exp_ack), .exp_res(exp_res),
        .out_valid(out_valid), .out_m(out_m)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] cin  [8];
    logic [7:0] mexp [8];

    // engine controls (written by main)
    bit rand_delay = 0;
    bit echo_mode  = 0;
    int fixed_delay = 0;
    int stray_reqs  = 0;

    // engine observations (written by engine)
    int         req_total    = 0;
    int         unstable_cnt = 0;
    int         gap_err_cnt  = 0;
    int         stray_seen   = 0;
    logic [7:0] obs_base [128];
    logic [7:0] obs_exp  [128];
    logic [7:0] obs_mod  [128];
    int         obs_cyc  [128];

    function automatic logic [7:0] modexp(input logic [7:0] b, input logic [7:0] e,
                                          input logic [7:0] m);
        logic [15:0] r;
        r = 16'd1;
        if (m == 8'd0) return 8'd0;
        for (int i = 0; i < int'(e); i++) r = (r * {8'd0, b}) % {8'd0, m};
        return r[7:0];
    endfunction

    // Behavioural modexp engine, sampled on the falling edge.
    initial begin
        logic [7:0] hb, he, hm;
        int  wait_left;
        bit  pending, prev_req;
        pending = 0; prev_req = 0; wait_left = 0; hb = 0; he = 0; hm = 0;
        exp_ack = 1'b0; exp_res = 8'd0;
        forever begin
            @(negedge clk);
            exp_ack = 1'b0;
            if (rst) begin
                pending = 0;
            end else if (stray_seen != stray_reqs) begin
                stray_seen++;
                exp_ack = 1'b1;
                exp_res = 8'hAA;
            end else if (exp_req) begin
                if (!pending) begin
                    if (prev_req) gap_err_cnt++;
                    pending = 1;
                    hb = exp_base; he = exp_exp; hm = exp_mod;
                    obs_base[req_total % 128] = hb;
                    obs_exp[req_total % 128]  = he;
                    obs_mod[req_total % 128]  = hm;
                    obs_cyc[req_total % 128]  = cyc;
                    req_total++;
                    wait_left = rand_delay ? int'($urandom_range(0, 20)) : fixed_delay;
                end else if (exp_base !== hb || exp_exp !== he || exp_mod !== hm) begin
                    unstable_cnt++;
                end
                if (wait_left == 0) begin
                    exp_ack = 1'b1;
                    exp_res = echo_mode ? hb : modexp(hb, he, hm);
                    pending = 0;
                end else begin
                    wait_left--;
                end
            end else begin
                pending = 0;
            end
            prev_req = exp_req;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic send_burst(input logic [3:0] p, input logic [3:0] q, input logic [7:0] e);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_p = (i == 0) ? p : 4'd0;
            in_q = (i == 0) ? q : 4'd0;
            in_e = (i == 0) ? e : 8'd0;
            in_c = cin[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_c = 8'd0;
    endtask

    task automatic collect_out(input bit poke);
        int t;
        t = 0;
        while (!out_valid && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("out_timeout", {31'd0, out_valid}, 1);
        for (int i = 0; i < 8; i++) begin
            check("out_valid_hi", {31'd0, out_valid}, 1);
            check("out_m", {24'd0, out_m}, {24'd0, mexp[i]});
            if (poke && i == 2) begin
                in_valid = 1'b1; in_p = 4'd2; in_q = 4'd3; in_e = 8'd3; in_c = 8'h55;
            end
            if (poke && i == 3) begin
                in_valid = 1'b0; in_p = 4'd0; in_q = 4'd0; in_e = 8'd0; in_c = 8'd0;
            end
            @(negedge clk);
        end
        check("out_valid_fall", {31'd0, out_valid}, 0);
        check("out_m_idle", {24'd0, out_m}, 0);
    endtask

    task automatic run_burst(input logic [3:0] p, input logic [3:0] q, input logic [7:0] e,
                             input logic [7:0] d, input logic [7:0] nmod,
                             input int max_lat, input bit poke);
        int base, start;
        base  = req_total;
        start = cyc;
        send_burst(p, q, e);
        collect_out(poke);
        check("req_count", req_total - base, 8);
        for (int i = 0; i < 8; i++) begin
            check("exp_base", {24'd0, obs_base[(base + i) % 128]}, {24'd0, cin[i]});
            check("exp_exp",  {24'd0, obs_exp[(base + i) % 128]},  {24'd0, d});
            check("exp_mod",  {24'd0, obs_mod[(base + i) % 128]},  {24'd0, nmod});
        end
        if (max_lat > 0)
            check("key_latency", {31'd0, (obs_cyc[base % 128] - start) <= max_lat}, 1);
        check("operand_stable", unstable_cnt, 0);
        check("req_gap", gap_err_cnt, 0);
    endtask

    task automatic load_t2;
        cin  = '{32, 48, 49, 0, 1, 5, 41, 37};
        mexp = '{2, 3, 4, 0, 1, 5, 6, 7};
    endtask

    task automatic load_t4;
        cin  = '{8, 26, 13, 10, 31, 17, 1, 27};
        mexp = '{2, 5, 7, 10, 4, 8, 1, 3};
    endtask

    task automatic load_echo;
        cin  = '{10, 20, 30, 40, 50, 60, 70, 80};
        mexp = '{10, 20, 30, 40, 50, 60, 70, 80};
    endtask

    initial begin
        int base, t, snap;
        rst = 1'b1; in_valid = 1'b0; in_p = 4'd0; in_q = 4'd0; in_e = 8'd0; in_c = 8'd0;
        repeat (3) @(negedge clk);

        check("rst_exp_req",   {31'd0, exp_req}, 0);
        check("rst_exp_base",  {24'd0, exp_base}, 0);
        check("rst_exp_exp",   {24'd0, exp_exp}, 0);
        check("rst_exp_mod",   {24'd0, exp_mod}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_m",     {24'd0, out_m}, 0);
        rst = 1'b0;
        @(negedge clk);

        // N=33, d=7, 2^7 mod 33 = 29 on every word
        cin  = '{2, 2, 2, 2, 2, 2, 2, 2};
        mexp = '{29, 29, 29, 29, 29, 29, 29, 29};
        run_burst(4'd3, 4'd11, 8'd3, 8'd7, 8'd33, 0, 1'b0);

        // N=65, phi=48, d=29; ciphertexts are m^5 mod 65
        load_t2();
        run_burst(4'd5, 4'd13, 8'd5, 8'd29, 8'd65, 56, 1'b0);

        // phi=2 -> d=1, engine echoes the base
        echo_mode = 1;
        load_echo();
        run_burst(4'd2, 4'd3, 8'd3, 8'd1, 8'd6, 0, 1'b0);
        echo_mode = 0;

        // random engine latency; ciphertexts are m^3 mod 33
        rand_delay = 1;
        load_t4();
        run_burst(4'd3, 4'd11, 8'd3, 8'd7, 8'd33, 0, 1'b0);
        rand_delay = 0;

        // reset while the fifth request (k=4) is outstanding
        fixed_delay = 10;
        base = req_total;
        send_burst(4'd3, 4'd11, 8'd3);
        t = 0;
        while (req_total < base + 5 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("rst_reach_k4", req_total - base, 5);
        #2 rst = 1'b1;
        #1;
        check("midrst_exp_req",   {31'd0, exp_req}, 0);
        check("midrst_out_valid", {31'd0, out_valid}, 0);
        check("midrst_exp_base",  {24'd0, exp_base}, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        stray_reqs++;
        fixed_delay = 0;
        snap = req_total;
        repeat (4) begin
            @(negedge clk);
            check("stray_ack_req", {31'd0, exp_req}, 0);
            check("stray_ack_out", {31'd0, out_valid}, 0);
        end
        check("stray_no_req", req_total - snap, 0);
        run_burst(4'd3, 4'd11, 8'd3, 8'd7, 8'd33, 0, 1'b0);

        // in_valid pulse during OUT must not start a new job
        echo_mode = 1;
        load_echo();
        run_burst(4'd2, 4'd3, 8'd3, 8'd1, 8'd6, 0, 1'b1);
        echo_mode = 0;
        snap = req_total;
        repeat (2) @(negedge clk);
        check("poke_no_req", req_total - snap, 0);
        check("poke_out_valid", {31'd0, out_valid}, 0);
        load_t2();
        run_burst(4'd5, 4'd13, 8'd5, 8'd29, 8'd65, 56, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
